// File: rtl/hs_pkg.sv
// Shared types for the handshake fan-in stage: default channel index, skid entry layout
// and the arbiter state encoding.
package hs_pkg;

    localparam int unsigned HS_NUM_CHANNEL = 4;
    localparam int unsigned HS_DATA_WIDTH  = 32;

    typedef logic [$clog2(HS_NUM_CHANNEL)-1:0] chan_idx_t;

    typedef struct packed {
        logic                     last;
        chan_idx_t                src_idx;
        logic [HS_DATA_WIDTH-1:0] data;
    } skid_entry_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/handshake_if.sv
// Valid/ready/data channel bundle with sender and receiver views.
interface handshake_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport sender   (output valid, output data, input  ready);
    modport receiver (input  valid, input  data, output ready);
endinterface

// File: rtl/handshake_skid_buf.sv
// Two-entry valid/ready register slice; push_space and pop_valid are pure flops so no
// combinational path exists from pop_ready back to push_space.
module handshake_skid_buf #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    input  T     push_data,
    output logic push_space,
    output logic pop_valid,
    output T     pop_data,
    input  logic pop_ready
);

    logic [1:0] cnt_r;
    logic [1:0] cnt_s;
    T           e0_r;
    T           e1_r;
    T           e0_s;
    T           e1_s;
    logic       space_r;
    logic       valid_r;
    logic       push_s;
    logic       pop_s;

    assign push_s     = push_valid && space_r;
    assign pop_s      = valid_r && pop_ready;
    assign push_space = space_r;
    assign pop_valid  = valid_r;
    assign pop_data   = e0_r;

    // Next occupancy and entry contents; e0 is always the head.
    always_comb begin
        cnt_s = cnt_r;
        e0_s  = e0_r;
        e1_s  = e1_r;
        case (cnt_r)
            2'd0: begin
                if (push_s) begin
                    e0_s  = push_data;
                    cnt_s = 2'd1;
                end else begin
                    cnt_s = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    e0_s = push_data;
                end else if (push_s) begin
                    e1_s  = push_data;
                    cnt_s = 2'd2;
                end else if (pop_s) begin
                    cnt_s = 2'd0;
                end else begin
                    cnt_s = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    e0_s  = e1_r;
                    cnt_s = 2'd1;
                end else begin
                    cnt_s = 2'd2;
                end
            end
            default: begin
                cnt_s = 2'd0;
            end
        endcase
    end

    // Storage, occupancy and the registered space/valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 2'd0;
            e0_r    <= '0;
            e1_r    <= '0;
            space_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            e0_r    <= e0_s;
            e1_r    <= e1_s;
            space_r <= (cnt_s != 2'd2);
            valid_r <= (cnt_s != 2'd0);
        end
    end

endmodule

// File: rtl/handshake_rr_arb_fi.sv
// Round-robin fan-in of NUM_CHANNEL handshake channels onto one link; a channel keeps the
// grant for a whole packet and every beat passes through a 2-entry skid buffer.
module handshake_rr_arb_fi
    import hs_pkg::*;
#(
    parameter int unsigned NUM_CHANNEL = HS_NUM_CHANNEL,
    parameter int unsigned DATA_WIDTH  = HS_DATA_WIDTH
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    handshake_if.receiver                  rx_if [NUM_CHANNEL],
    input  logic [NUM_CHANNEL-1:0]         i_last,
    handshake_if.sender                    tx_if,
    output logic [$clog2(NUM_CHANNEL)-1:0] o_src_idx,
    output logic                           o_last
);

    localparam int unsigned IDX_W = $clog2(NUM_CHANNEL);

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic                  last;
        idx_t                  src_idx;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    if (NUM_CHANNEL < 2) begin : g_bad_num_channel
        $error("handshake_rr_arb_fi: NUM_CHANNEL must be at least 2");
    end

    function automatic idx_t inc_wrap(input idx_t i);
        if (i == idx_t'(NUM_CHANNEL - 1)) begin
            return idx_t'(0);
        end else begin
            return i + idx_t'(1);
        end
    endfunction

    logic [NUM_CHANNEL-1:0] valid_s;
    logic [DATA_WIDTH-1:0]  data_s [NUM_CHANNEL];
    idx_t                   grant_s;
    idx_t                   cand_s;
    idx_t                   sel_s;
    idx_t                   ptr_r;
    idx_t                   ptr_s;
    idx_t                   gnt_r;
    idx_t                   gnt_s;
    logic                   found_s;
    logic                   sel_en_s;
    logic                   last_sel_s;
    logic                   acc_s;
    logic                   space_s;
    logic                   head_valid_s;
    arb_state_e             state_r;
    arb_state_e             state_s;
    entry_t                 push_entry_s;
    entry_t                 head_s;

    for (genvar g = 0; g < NUM_CHANNEL; g++) begin : g_ch
        assign valid_s[g] = rx_if[g].valid;
        assign data_s[g]  = rx_if[g].data;

        // Only the selected channel sees ready, and only while the skid buffer has room.
        always_comb begin
            rx_if[g].ready = space_s && sel_en_s && (sel_s == idx_t'(g));
        end
    end

    // Round-robin search: first valid channel starting at ptr_r, wrapping modulo NUM_CHANNEL.
    always_comb begin
        found_s = 1'b0;
        grant_s = ptr_r;
        cand_s  = ptr_r;
        for (int k = 0; k < NUM_CHANNEL; k++) begin
            if (!found_s && valid_s[cand_s]) begin
                found_s = 1'b1;
                grant_s = cand_s;
            end else begin
                found_s = found_s;
            end
            cand_s = inc_wrap(cand_s);
        end
    end

    assign sel_s        = (state_r == LOCKED) ? gnt_r : grant_s;
    assign sel_en_s     = (state_r == LOCKED) || found_s;
    assign last_sel_s   = i_last[sel_s];
    assign acc_s        = sel_en_s && valid_s[sel_s] && space_s;
    assign push_entry_s = '{last: last_sel_s, src_idx: sel_s, data: data_s[sel_s]};

    // Packet-lock FSM: the pointer only advances when a packet's last beat is taken.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        gnt_s   = gnt_r;
        case (state_r)
            IDLE: begin
                if (acc_s && last_sel_s) begin
                    ptr_s = inc_wrap(grant_s);
                end else if (acc_s) begin
                    gnt_s   = grant_s;
                    state_s = LOCKED;
                end else begin
                    state_s = IDLE;
                end
            end
            LOCKED: begin
                if (acc_s && last_sel_s) begin
                    ptr_s   = inc_wrap(gnt_r);
                    state_s = IDLE;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            ptr_r   <= idx_t'(0);
            gnt_r   <= idx_t'(0);
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            gnt_r   <= gnt_s;
        end
    end

    handshake_skid_buf #(
        .T (entry_t)
    ) u_skid (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .push_valid (acc_s),
        .push_data  (push_entry_s),
        .push_space (space_s),
        .pop_valid  (head_valid_s),
        .pop_data   (head_s),
        .pop_ready  (tx_if.ready)
    );

    assign tx_if.valid = head_valid_s;
    assign tx_if.data  = head_s.data;
    assign o_src_idx   = head_s.src_idx;
    assign o_last      = head_s.last;

endmodule

// File: tb/tb_handshake_rr_arb_fi.sv
// Self-checking bench for handshake_rr_arb_fi: a beat-queue model checked every cycle,
// plus directed scenarios with literal expectations on the delivered beat stream.
module tb_handshake_rr_arb_fi;

    localparam int NCH = 4;
    localparam int DW  = 32;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int            src;
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } rec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] rx_valid;
    logic [NCH-1:0] rx_ready;
    logic [NCH-1:0] rx_last;
    logic [DW-1:0]  rx_data [NCH];
    logic           tx_ready;
    logic           tx_valid;
    logic [DW-1:0]  tx_data;
    logic [1:0]     src_idx;
    logic           o_last;

    handshake_if #(.DATA_WIDTH(DW)) rx_if [NCH] ();
    handshake_if #(.DATA_WIDTH(DW)) tx_if ();

    for (genvar g = 0; g < NCH; g++) begin : g_tb
        assign rx_if[g].valid = rx_valid[g];
        assign rx_if[g].data  = rx_data[g];
        assign rx_ready[g]    = rx_if[g].ready;
    end
    assign tx_if.ready = tx_ready;
    assign tx_valid    = tx_if.valid;
    assign tx_data     = tx_if.data;

    handshake_rr_arb_fi #(
        .NUM_CHANNEL (NCH),
        .DATA_WIDTH  (DW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .rx_if     (rx_if),
        .i_last    (rx_last),
        .tx_if     (tx_if),
        .o_src_idx (src_idx),
        .o_last    (o_last)
    );

    always #5 clk = ~clk;

    beat_t          src_q [NCH][$];
    rec_t           m_q[$];
    rec_t           log_q[$];
    int             m_ptr;
    int             m_owner;
    bit             m_space_ok;
    logic [NCH-1:0] acc_flag;
    int             acc_cnt [NCH];
    int             cyc;
    int             first_acc_cyc;
    int             n_checks;
    int             n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            if (src_q[i].size() > 0) begin
                rx_valid[i] = 1'b1;
                rx_data[i]  = src_q[i][0].data;
                rx_last[i]  = src_q[i][0].last;
            end else begin
                rx_valid[i] = 1'b0;
                rx_data[i]  = '0;
                rx_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic push_pkt(input int ch, input int n, input logic [DW-1:0] base);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.last = (k == n - 1);
            b.data = base + DW'(k);
            src_q[ch].push_back(b);
        end
        drive();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (acc_flag[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
                acc_cnt[i]++;
            end
        end
        drive();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NCH; i++) begin
            if (src_q[i].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        while ((!all_empty() || tx_valid) && n < max_cyc) begin
            step();
            n++;
        end
        check({name, "_timeout"}, 64'(n >= max_cyc), 64'(0));
    endtask

    task automatic expect_beat(input string name, input int k, input int src,
                               input logic [DW-1:0] data, input logic last);
        if (k < log_q.size()) begin
            check($sformatf("%s[%0d]_src", name, k), 64'(log_q[k].src), 64'(src));
            check($sformatf("%s[%0d]_data", name, k), 64'(log_q[k].data), 64'(data));
            check($sformatf("%s[%0d]_last", name, k), 64'(log_q[k].last), 64'(last));
        end else begin
            check($sformatf("%s[%0d]_missing", name, k), 64'(log_q.size()), 64'(k + 1));
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ready"}, 64'(rx_ready), 64'(0));
        check({name, "_tx_valid"}, 64'(tx_valid), 64'(0));
        check({name, "_src"}, 64'(src_idx), 64'(0));
        check({name, "_last"}, 64'(o_last), 64'(0));
    endtask

    // Cycle model: compare, record transfers, then advance the model to the next edge.
    always @(negedge clk) begin
        int   grant;
        bit   sp;
        bit   m_acc;
        rec_t r;
        cyc++;
        if (!rst_n) begin
            m_q.delete();
            m_ptr      = 0;
            m_owner    = -1;
            m_space_ok = 1'b0;
            acc_flag   = '0;
            check("rst_ready", 64'(rx_ready), 64'(0));
            check("rst_tx_valid", 64'(tx_valid), 64'(0));
        end else begin
            grant = -1;
            if (m_owner >= 0) begin
                grant = m_owner;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (grant < 0 && rx_valid[(m_ptr + k) % NCH]) grant = (m_ptr + k) % NCH;
                end
            end
            sp = m_space_ok && (m_q.size() < 2);
            for (int i = 0; i < NCH; i++) begin
                check($sformatf("ready[%0d]", i), 64'(rx_ready[i]), 64'(sp && grant == i));
            end
            check("tx_valid", 64'(tx_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                check("tx_data", 64'(tx_data), 64'(m_q[0].data));
                check("tx_src", 64'(src_idx), 64'(m_q[0].src));
                check("tx_last", 64'(o_last), 64'(m_q[0].last));
            end
            acc_flag = rx_valid & rx_ready;
            if (first_acc_cyc < 0 && |acc_flag) first_acc_cyc = cyc;
            if (tx_valid && tx_ready) begin
                r.src  = int'(src_idx);
                r.data = tx_data;
                r.last = o_last;
                r.cyc  = cyc;
                log_q.push_back(r);
            end
            m_acc = sp && grant >= 0 && rx_valid[grant];
            if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
            if (m_acc) begin
                r.src  = grant;
                r.data = rx_data[grant];
                r.last = rx_last[grant];
                r.cyc  = cyc;
                m_q.push_back(r);
                if (rx_last[grant]) begin
                    m_ptr   = (grant + 1) % NCH;
                    m_owner = -1;
                end else begin
                    m_owner = grant;
                end
            end
            m_space_ok = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        first_acc_cyc = -1;
        acc_flag      = '0;
        rst_n         = 1'b0;
        tx_ready      = 1'b1;
        for (int i = 0; i < NCH; i++) acc_cnt[i] = 0;
        drive();

        // Reset held with random input valids.
        for (int i = 0; i < NCH; i++) begin
            if (i == 0 || $urandom_range(0, 1) == 1) push_pkt(i, 2, 32'h5000 + 32'(i * 16));
        end
        repeat (3) begin
            step();
            check_idle_outputs("reset");
        end
        for (int i = 0; i < NCH; i++) src_q[i].delete();
        drive();
        step();
        rst_n = 1'b1;

        // Round robin over single-beat packets, one beat per cycle.
        log_q.delete();
        first_acc_cyc = -1;
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < NCH; ch++) push_pkt(ch, 1, 32'h100 + 32'(ch * 16 + k));
        end
        wait_idle("rr", 100);
        check("rr_count", 64'(log_q.size()), 64'(12));
        for (int k = 0; k < 12; k++) begin
            expect_beat("rr", k, k % 4, 32'h100 + 32'((k % 4) * 16 + k / 4), 1'b1);
            if (k < log_q.size()) check($sformatf("rr_cyc[%0d]", k), 64'(log_q[k].cyc), 64'(log_q[0].cyc + k));
        end
        if (log_q.size() > 0) check("rr_latency", 64'(log_q[0].cyc), 64'(first_acc_cyc + 1));
        check("rr_ptr_model", 64'(m_ptr), 64'(0));

        // Packet lock: channel 1 holds the grant for A,B,C while channel 0 waits.
        push_pkt(0, 1, 32'hC0);
        wait_idle("lock_pre", 50);
        log_q.delete();
        push_pkt(1, 3, 32'hA);
        push_pkt(0, 1, 32'hD0);
        wait_idle("lock", 50);
        check("lock_count", 64'(log_q.size()), 64'(4));
        expect_beat("lock", 0, 1, 32'hA, 1'b0);
        expect_beat("lock", 1, 1, 32'hB, 1'b0);
        expect_beat("lock", 2, 1, 32'hC, 1'b1);
        expect_beat("lock", 3, 0, 32'hD0, 1'b1);
        check("lock_ptr_model", 64'(m_ptr), 64'(1));

        // Backpressure: two beats fill the skid buffer, then channel 2 stalls.
        log_q.delete();
        tx_ready   = 1'b0;
        acc_cnt[2] = 0;
        push_pkt(2, 6, 32'h200);
        repeat (5) step();
        check("bp_accepts", 64'(acc_cnt[2]), 64'(2));
        check("bp_ready", 64'(rx_ready[2]), 64'(0));
        check("bp_tx_valid", 64'(tx_valid), 64'(1));
        tx_ready = 1'b1;
        wait_idle("bp", 50);
        check("bp_count", 64'(log_q.size()), 64'(6));
        for (int k = 0; k < 6; k++) expect_beat("bp", k, 2, 32'h200 + 32'(k), k == 5);

        // Wrap-around: after channel 2, channel 3 precedes channel 0.
        log_q.delete();
        push_pkt(3, 1, 32'h33);
        push_pkt(0, 1, 32'h30);
        wait_idle("wrap", 50);
        check("wrap_count", 64'(log_q.size()), 64'(2));
        expect_beat("wrap", 0, 3, 32'h33, 1'b1);
        expect_beat("wrap", 1, 0, 32'h30, 1'b1);
        check("wrap_ptr_model", 64'(m_ptr), 64'(1));

        // Reset in the middle of a channel 3 packet.
        log_q.delete();
        acc_cnt[3] = 0;
        push_pkt(3, 3, 32'h3A0);
        n = 0;
        while (acc_cnt[3] == 0 && n < 20) begin
            step();
            n++;
        end
        check("midrst_accept_timeout", 64'(n >= 20), 64'(0));
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst_async");
        for (int i = 0; i < NCH; i++) src_q[i].delete();
        drive();
        step();
        push_pkt(0, 1, 32'hE0);
        push_pkt(3, 1, 32'hE3);
        step();
        rst_n = 1'b1;
        wait_idle("midrst", 50);
        check("midrst_count", 64'(log_q.size()), 64'(2));
        expect_beat("midrst", 0, 0, 32'hE0, 1'b1);
        expect_beat("midrst", 1, 3, 32'hE3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
